// File: rtl/edge_detect_mc.sv
// Multi-channel edge detector: per-channel synchroniser, stability filter,
// mode-qualified edge pulse/polarity, sticky flag and saturating edge counter.

module edge_detect_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_in,
  input  logic [1:0]       i_mode,
  input  logic             i_flag_clr,
  input  logic             i_cnt_clr,
  output logic             o_level,
  output logic             o_pulse,
  output logic             o_type,
  output logic             o_flag,
  output logic [CNT_W-1:0] o_cnt
);
  localparam int FW = (FILT_CYC < 2) ? 1 : $clog2(FILT_CYC + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level, r_pulse, r_type, r_flag;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_s, w_lvl_nxt, w_chg, w_qual;

  always_ff @(posedge clk) begin
    if (!rstn) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  generate
    if (FILT_CYC >= 2) begin : g_filt
      logic [FW-1:0] r_fcnt;
      logic          w_hit;
      // Level flips on the edge where the disagreement run would reach FILT_CYC.
      assign w_hit     = (w_s != r_level) && (r_fcnt == FW'(FILT_CYC - 1));
      assign w_lvl_nxt = w_hit ? ~r_level : r_level;
      always_ff @(posedge clk) begin
        if (!rstn)                      r_fcnt <= '0;
        else if (w_s == r_level || w_hit) r_fcnt <= '0;
        else                            r_fcnt <= r_fcnt + 1'b1;
      end
    end else begin : g_nofilt
      assign w_lvl_nxt = w_s;
    end
  endgenerate

  assign w_chg  = w_lvl_nxt != r_level;
  assign w_qual = w_chg && (w_lvl_nxt ? i_mode[0] : i_mode[1]);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_type  <= 1'b0;
      r_flag  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_level <= w_lvl_nxt;
      r_pulse <= w_qual;
      r_type  <= w_qual & w_lvl_nxt;
      if (w_qual)          r_flag <= 1'b1;
      else if (i_flag_clr) r_flag <= 1'b0;
      // A clear coincident with a qualified edge counts that edge.
      if (i_cnt_clr)                r_cnt <= w_qual ? CNT_W'(1) : '0;
      else if (w_qual && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;
  assign o_type  = r_type;
  assign o_flag  = r_flag;
  assign o_cnt   = r_cnt;
endmodule

module edge_detect_mc #(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [CH_NUM-1:0]       edge_in,
  input  logic [2*CH_NUM-1:0]     mode,
  input  logic [CH_NUM-1:0]       flag_clr,
  input  logic                    cnt_clr,
  output logic [CH_NUM-1:0]       level_out,
  output logic [CH_NUM-1:0]       edge_pulse,
  output logic [CH_NUM-1:0]       edge_type,
  output logic [CH_NUM-1:0]       flag,
  output logic [CH_NUM*CNT_W-1:0] edge_cnt
);
  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      edge_detect_ch #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYC   (FILT_CYC),
        .CNT_W      (CNT_W)
      ) u_ch (
        .clk       (clk),
        .rstn      (rstn),
        .i_in      (edge_in[gi]),
        .i_mode    (mode[2*gi +: 2]),
        .i_flag_clr(flag_clr[gi]),
        .i_cnt_clr (cnt_clr),
        .o_level   (level_out[gi]),
        .o_pulse   (edge_pulse[gi]),
        .o_type    (edge_type[gi]),
        .o_flag    (flag[gi]),
        .o_cnt     (edge_cnt[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate
endmodule

// File: doc/edge_detect_mc.md
Name: edge_detect_mc

Overview:
Multi-channel, parametrised edge detector and successor to the single-channel rise/fall detector. Each channel has:
- a synchroniser for the asynchronous input;
- a stability (glitch) filter;
- per-channel selectable detection mode (off/rise/fall/both);
- a one-cycle edge pulse with edge polarity, a sticky flag, and a saturating edge counter.

It sits between raw external or cross-domain inputs (buttons, status lines) and control FSMs or register-file status bits.

Parameters:
CH_NUM, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_CYC, 4, consecutive stable cycles needed to accept a new level (0 and 1 both mean no filtering)
CNT_W, 8, width of each per-channel edge counter (>=1)

Ports:
clk  input  1  single clock, rising edge
rstn  input  1  reset, synchronous, active-low
edge_in  input  CH_NUM  asynchronous raw inputs, bit i = channel i
mode  input  2*CH_NUM  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
flag_clr  input  CH_NUM  per-channel sticky-flag clear, level, synchronous
cnt_clr  input  1  clears all edge counters, synchronous
level_out  output  CH_NUM  filtered, synchronised level
edge_pulse  output  CH_NUM  one-cycle pulse on a qualified edge
edge_type  output  CH_NUM  1 = rising, 0 = falling; valid only while edge_pulse[i]=1, else 0
flag  output  CH_NUM  sticky: set on a qualified edge
edge_cnt  output  CH_NUM*CNT_W  per-channel qualified-edge count, bits [(i+1)*CNT_W-1:i*CNT_W]

Behaviour:
- Reset (rstn=0 at a clk edge): all sync flops, filter counters, level_out, edge_pulse, edge_type, flag and edge_cnt go to 0.
- Reset takes effect mid-operation: in-progress filter counts are discarded, and no pulse is generated for a pre-reset transition.
- Because level resets to 0, an input held at 1 through reset release produces one rising edge after the normal latency.
- Synchroniser: edge_in[i] shifts through SYNC_STAGES flops; s_i denotes the last stage.
- Filter (FILT_CYC >= 2):
  - A per-channel counter of width clog2(FILT_CYC+1) counts cycles where s_i != level_out[i].
  - The counter resets to 0 on any cycle where s_i == level_out[i].
  - level_out[i] toggles, and the counter resets, on the clock edge where the counter would reach FILT_CYC.
  - Pulses shorter than FILT_CYC cycles at s_i never change level_out.
- FILT_CYC 0/1: level_out[i] <= s_i every cycle.
- Latency: from the first clk edge that samples the new edge_in value to the change of level_out is SYNC_STAGES + max(FILT_CYC,1) clock edges (default 6).
- Edge detection: a raw edge is the clock edge where level_out[i] changes. edge_pulse[i] and edge_type[i] are registered and assert in the same cycle level_out[i] shows the new value, for exactly one cycle.
- Qualification: rise requires mode[2i]=1; fall requires mode[2i+1]=1. The mode value sampled on the edge that updates level_out applies. Unqualified edges produce no pulse, flag or count.
- Level tracking (level_out) runs regardless of mode.
- Consecutive edges: back-to-back qualified edges are impossible with filtering enabled. With FILT_CYC<=1, an input toggling every cycle produces a pulse every cycle.
- flag[i]: set on a qualified edge; cleared when flag_clr[i]=1. Simultaneous set and clear: set wins, flag stays 1.
- edge_cnt[i]: +1 per qualified edge, saturating at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 clears all counters to 0.
  - cnt_clr together with a qualified edge on channel i: edge_cnt[i] becomes 1.
- Channels are fully independent; simultaneous edges on several channels are each handled in the same cycle.

Test Plan:
- Defaults, mode=8'h55 (all rise). edge_in[0] goes 0->1 and holds 20 cycles -> edge_pulse[0]=1 for exactly 1 cycle, 6 edges after sampling; edge_type[0]=1, level_out[0]=1, flag[0]=1, edge_cnt[0]=1; other channels stay 0.
- Glitch: edge_in[1] high for 3 cycles, then low (FILT_CYC=4) -> level_out[1] stays 0, no pulse, edge_cnt[1]=0. A 4-cycle-stable high is accepted.
- Mode both on ch2 (mode[5:4]=11): pulse 0->1 held 10, then 1->0 held 10 -> two pulses with edge_type 1 then 0, edge_cnt[2]=2. Repeat with mode 01 -> only the rising pulse, count +1. With mode 00 -> level_out tracks, no pulse.
- Saturation, CNT_W=4, FILT_CYC=0, ch3 mode rise: 20 rising edges -> edge_cnt[3]=15. cnt_clr coincident with a qualified edge -> edge_cnt[3]=1.
- Flag: flag_clr[0] asserted in the same cycle as a qualified pulse -> flag[0] remains 1. A later flag_clr[0] alone -> flag[0]=0 next cycle.
- Reset: rstn=0 for 1 cycle while ch0's filter count=2 after 0->1 -> all outputs 0. With the input still high, exactly one rising pulse occurs 6 cycles after reset release; no pulse occurs for the aborted pre-reset transition.
